// File: rtl/fwd_hazard_scoreboard_if.sv
// Pipeline-side bundle for the forwarding / hazard scoreboard: operand
// sources, EX/MEM and MEM/WB writeback info, long-latency issue/completion,
// and the resulting mux selects, stall and status.
interface fwd_hazard_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RPORTS     = 2
);
  logic                                 id_exe_valid;
  logic [NUM_RPORTS*REG_ADDR_WIDTH-1:0] id_exe_reg_raddr;
  logic [REG_ADDR_WIDTH-1:0]            exe_mem_reg_waddr;
  logic                                 exe_mem_reg_wen;
  logic                                 exe_mem_is_load;
  logic [REG_ADDR_WIDTH-1:0]            mem_wb_reg_waddr;
  logic                                 mem_wb_reg_wen;
  logic                                 iss_valid;
  logic [REG_ADDR_WIDTH-1:0]            iss_waddr;
  logic                                 iss_ready;
  logic                                 cmpl_valid;
  logic [REG_ADDR_WIDTH-1:0]            cmpl_waddr;
  logic [NUM_RPORTS*2-1:0]              forwarding;
  logic                                 stall;
  logic                                 sb_err;
  logic [31:0]                          stall_cycles;

  // pipeline side
  modport master (
    output id_exe_valid, id_exe_reg_raddr, exe_mem_reg_waddr, exe_mem_reg_wen,
           exe_mem_is_load, mem_wb_reg_waddr, mem_wb_reg_wen, iss_valid,
           iss_waddr, cmpl_valid, cmpl_waddr,
    input  iss_ready, forwarding, stall, sb_err, stall_cycles
  );

  // scoreboard side
  modport slave (
    input  id_exe_valid, id_exe_reg_raddr, exe_mem_reg_waddr, exe_mem_reg_wen,
           exe_mem_is_load, mem_wb_reg_waddr, mem_wb_reg_wen, iss_valid,
           iss_waddr, cmpl_valid, cmpl_waddr,
    output iss_ready, forwarding, stall, sb_err, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding mux select, load-use / pending-write stall detection and a
// per-register scoreboard of outstanding long-latency writes.

// Per-source-port hazard check: picks the forwarding source and flags a stall.
module fwd_port_chk #(
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    exe_waddr,
  input  logic             exe_wen,
  input  logic             exe_load,
  input  logic [AW-1:0]    mem_waddr,
  input  logic             mem_wen,
  input  logic             cmpl_valid,
  input  logic [AW-1:0]    cmpl_waddr,
  input  logic [CNT_W-1:0] cnt_s,
  output logic [1:0]       sel,
  output logic             hz
);
  logic nz, exe_hit, mem_hit, cmpl_hit;

  assign nz       = (src != '0);
  assign exe_hit  = nz && exe_wen && (exe_waddr == src);
  assign mem_hit  = nz && mem_wen && (mem_waddr == src);
  assign cmpl_hit = nz && cmpl_valid && (cmpl_waddr == src);

  // first match wins: youngest producer first, completion only when it is the last one pending
  always_comb begin
    sel = 2'b00;
    if (exe_hit && !exe_load)                   sel = 2'b01;
    else if (mem_hit)                           sel = 2'b10;
    else if (cmpl_hit && cnt_s == CNT_W'(1))    sel = 2'b11;
  end

  // load-use, or writes still pending after this cycle's completion
  assign hz = (exe_hit && exe_load) || (nz && (cnt_s > CNT_W'(cmpl_hit)));
endmodule

module fwd_hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RPORTS     = 2,
  parameter int MAX_PENDING    = 3,
  parameter int CNT_W          = $clog2(MAX_PENDING + 1)
) (
  input logic clk,
  input logic rst,
  fwd_hazard_scoreboard_if.slave bus
);
  localparam int AW    = REG_ADDR_WIDTH;
  localparam int NREGS = 2 ** REG_ADDR_WIDTH;

  logic [NREGS-1:0][CNT_W-1:0]      cnt;
  logic [NUM_RPORTS-1:0][AW-1:0]    src;
  logic [NUM_RPORTS-1:0][CNT_W-1:0] cnt_s;
  logic [NUM_RPORTS-1:0][1:0]       sel;
  logic [NUM_RPORTS-1:0]            hz;
  logic [NREGS-1:0]                 inc, dec, err;
  logic                             cmpl_iss;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    assign src[p]   = bus.id_exe_reg_raddr[p*AW +: AW];
    assign cnt_s[p] = cnt[src[p]];
    fwd_port_chk #(.AW(AW), .CNT_W(CNT_W)) u_chk (
      .src        (src[p]),
      .exe_waddr  (bus.exe_mem_reg_waddr),
      .exe_wen    (bus.exe_mem_reg_wen),
      .exe_load   (bus.exe_mem_is_load),
      .mem_waddr  (bus.mem_wb_reg_waddr),
      .mem_wen    (bus.mem_wb_reg_wen),
      .cmpl_valid (bus.cmpl_valid),
      .cmpl_waddr (bus.cmpl_waddr),
      .cnt_s      (cnt_s[p]),
      .sel        (sel[p]),
      .hz         (hz[p])
    );
  end

  assign bus.forwarding = sel;
  assign bus.stall      = bus.id_exe_valid && (|hz);

  // a completion to the same register frees the slot this cycle
  assign cmpl_iss      = bus.cmpl_valid && (bus.cmpl_waddr == bus.iss_waddr);
  assign bus.iss_ready = (cnt[bus.iss_waddr] < CNT_W'(MAX_PENDING)) || cmpl_iss;

  // per-register issue/completion decode; x0 is never tracked
  always_comb begin
    inc = '0;
    dec = '0;
    err = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc[r] = bus.iss_valid && bus.iss_ready && (bus.iss_waddr == AW'(r));
      dec[r] = bus.cmpl_valid && (bus.cmpl_waddr == AW'(r));
      err[r] = dec[r] && !inc[r] && (cnt[r] == '0);
    end
  end

  // pending counters and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bus.sb_err <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (inc[r] && !dec[r])                     cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec[r] && !inc[r] && cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (|err) bus.sb_err <= 1'b1;
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst)                                  bus.stall_cycles <= '0;
    else if (bus.stall && bus.stall_cycles != '1) bus.stall_cycles <= bus.stall_cycles + 32'd1;
  end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with hand-computed expectations.
module tb_fwd_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.REG_ADDR_WIDTH(5), .NUM_RPORTS(2)) bus ();

  fwd_hazard_scoreboard #(.REG_ADDR_WIDTH(5), .NUM_RPORTS(2), .MAX_PENDING(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_exe_valid      = 1'b0;
    bus.id_exe_reg_raddr  = '0;
    bus.exe_mem_reg_waddr = '0;
    bus.exe_mem_reg_wen   = 1'b0;
    bus.exe_mem_is_load   = 1'b0;
    bus.mem_wb_reg_waddr  = '0;
    bus.mem_wb_reg_wen    = 1'b0;
    bus.iss_valid         = 1'b0;
    bus.iss_waddr         = '0;
    bus.cmpl_valid        = 1'b0;
    bus.cmpl_waddr        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src2(input logic [4:0] p1, input logic [4:0] p0);
    bus.id_exe_reg_raddr = {p1, p0};
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_fwd", 32'(bus.forwarding), 32'd0);
    chk("rst_sb_err", 32'(bus.sb_err), 32'd0);
    chk("rst_stall_cycles", bus.stall_cycles, 32'd0);

    // EX/MEM beats MEM/WB
    bus.id_exe_valid = 1'b1; src2(5'd0, 5'd5);
    bus.exe_mem_reg_wen = 1'b1; bus.exe_mem_reg_waddr = 5'd5;
    bus.mem_wb_reg_wen = 1'b1;  bus.mem_wb_reg_waddr = 5'd5;
    #1;
    chk("fwd_exe_prio", 32'(bus.forwarding), 32'h1);
    chk("fwd_exe_nostall", 32'(bus.stall), 32'd0);
    bus.exe_mem_reg_wen = 1'b0; src2(5'd5, 5'd5);
    #1;
    chk("fwd_mem_both", 32'(bus.forwarding), 32'hA);

    // load-use
    idle(); bus.id_exe_valid = 1'b1; src2(5'd7, 5'd0);
    bus.exe_mem_reg_wen = 1'b1; bus.exe_mem_is_load = 1'b1; bus.exe_mem_reg_waddr = 5'd7;
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    chk("lu_fwd", 32'(bus.forwarding), 32'd0);
    tick();
    chk("lu_cycles", bus.stall_cycles, 32'd1);
    bus.id_exe_valid = 1'b0;
    #1;
    chk("lu_invalid_nostall", 32'(bus.stall), 32'd0);
    tick();
    chk("lu_cycles_hold", bus.stall_cycles, 32'd1);

    // long-latency x9: issue cycle 0, consumer cycles 1..4, completion cycle 4
    idle(); bus.iss_valid = 1'b1; bus.iss_waddr = 5'd9;
    #1;
    chk("x9_iss_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    idle(); bus.id_exe_valid = 1'b1; src2(5'd0, 5'd9);
    #1;
    chk("x9_c1_stall", 32'(bus.stall), 32'd1);
    tick(); tick(); tick();
    chk("x9_cycles", bus.stall_cycles, 32'd4);
    bus.cmpl_valid = 1'b1; bus.cmpl_waddr = 5'd9;
    #1;
    chk("x9_c4_stall", 32'(bus.stall), 32'd0);
    chk("x9_c4_fwd", 32'(bus.forwarding), 32'h3);
    // EX/MEM still outranks the completion
    bus.exe_mem_reg_wen = 1'b1; bus.exe_mem_reg_waddr = 5'd9;
    #1;
    chk("x9_exe_over_cmpl", 32'(bus.forwarding), 32'h1);
    bus.exe_mem_reg_wen = 1'b0;
    tick();
    bus.cmpl_valid = 1'b0;
    #1;
    chk("x9_c5_stall", 32'(bus.stall), 32'd0);
    chk("x9_c5_fwd", 32'(bus.forwarding), 32'd0);
    chk("x9_sb_err", 32'(bus.sb_err), 32'd0);

    // x3 up to MAX_PENDING
    idle(); bus.iss_valid = 1'b1; bus.iss_waddr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("x3_ready_%0d", i), 32'(bus.iss_ready), 32'd1);
      tick();
    end
    chk("x3_full", 32'(bus.iss_ready), 32'd0);
    tick();
    chk("x3_dropped", 32'(bus.iss_ready), 32'd0);
    bus.cmpl_valid = 1'b1; bus.cmpl_waddr = 5'd3;
    bus.id_exe_valid = 1'b1; src2(5'd3, 5'd0);
    #1;
    chk("x3_ready_cmpl", 32'(bus.iss_ready), 32'd1);
    chk("x3_stall_cmpl", 32'(bus.stall), 32'd1);
    tick();
    bus.iss_valid = 1'b0; bus.cmpl_valid = 1'b0;
    #1;
    chk("x3_still_full", 32'(bus.iss_ready), 32'd0);
    chk("x3_stall", 32'(bus.stall), 32'd1);
    bus.iss_valid = 1'b1;
    #1;
    chk("x3_still_notready", 32'(bus.iss_ready), 32'd0);
    bus.iss_valid = 1'b0; bus.id_exe_valid = 1'b0;
    bus.cmpl_valid = 1'b1;
    tick(); tick(); tick();
    bus.cmpl_valid = 1'b0; bus.id_exe_valid = 1'b1;
    #1;
    chk("x3_drained_stall", 32'(bus.stall), 32'd0);
    chk("x3_drained_err", 32'(bus.sb_err), 32'd0);

    // spurious completion
    idle(); bus.cmpl_valid = 1'b1; bus.cmpl_waddr = 5'd4;
    tick();
    chk("x4_sb_err", 32'(bus.sb_err), 32'd1);
    idle();
    tick();
    chk("x4_sb_err_sticky", 32'(bus.sb_err), 32'd1);

    // reset clears pending state
    bus.iss_valid = 1'b1; bus.iss_waddr = 5'd5;
    tick();
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_sb_err", 32'(bus.sb_err), 32'd0);
    chk("rst2_cycles", bus.stall_cycles, 32'd0);
    bus.id_exe_valid = 1'b1; src2(5'd5, 5'd5);
    #1;
    chk("rst2_x5_nostall", 32'(bus.stall), 32'd0);

    // x0 never forwards, stalls or tracks
    idle(); bus.id_exe_valid = 1'b1; src2(5'd0, 5'd0);
    bus.exe_mem_reg_wen = 1'b1; bus.exe_mem_is_load = 1'b1; bus.exe_mem_reg_waddr = 5'd0;
    bus.mem_wb_reg_wen = 1'b1; bus.mem_wb_reg_waddr = 5'd0;
    bus.iss_valid = 1'b1; bus.iss_waddr = 5'd0;
    #1;
    chk("x0_fwd", 32'(bus.forwarding), 32'd0);
    chk("x0_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.iss_valid = 1'b0; bus.cmpl_valid = 1'b1; bus.cmpl_waddr = 5'd0;
    #1;
    chk("x0_fwd_cmpl", 32'(bus.forwarding), 32'd0);
    tick();
    chk("x0_no_err", 32'(bus.sb_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor of the pipeline forwarding unit. Adds an N-read-port forwarding mux select and load-use stall detection.
- Adds a per-register pending-write scoreboard for long-latency writers (multi-cycle LSU, divider). Those writers are issued from EX and complete out of band.
- Sits beside ID/EX. Drives the EX operand mux selects and the pipeline stall/hold. Also keeps a stall-cycle performance counter.

Parameters:
- REG_ADDR_WIDTH, 5, register index width; NREGS = 2**REG_ADDR_WIDTH.
- NUM_RPORTS, 2, number of EX source operands checked.
- MAX_PENDING, 3, max outstanding long-latency writes per register (≥1).
- CNT_W, $clog2(MAX_PENDING+1), per-register pending-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_exe_valid  in  1  ID/EX holds a real instruction
- id_exe_reg_raddr  in  NUM_RPORTS*REG_ADDR_WIDTH  packed source indices, port p at [p*AW +: AW]
- exe_mem_reg_waddr  in  REG_ADDR_WIDTH  EX/MEM destination
- exe_mem_reg_wen  in  1  EX/MEM writes regfile
- exe_mem_is_load  in  1  EX/MEM result not yet available (load)
- mem_wb_reg_waddr  in  REG_ADDR_WIDTH  MEM/WB destination
- mem_wb_reg_wen  in  1  MEM/WB writes regfile
- iss_valid  in  1  long-latency op issuing this cycle
- iss_waddr  in  REG_ADDR_WIDTH  its destination
- iss_ready  out  1  scoreboard can accept issue
- cmpl_valid  in  1  long-latency result writing back this cycle
- cmpl_waddr  in  REG_ADDR_WIDTH  its destination
- forwarding  out  NUM_RPORTS*2  per-port select: 00 ID_EX, 01 EXE_MEM, 10 MEM_WB, 11 CMPL
- stall  out  1  hold IF/ID/EX and bubble EX/MEM
- sb_err  out  1  sticky: completion to a non-pending register
- stall_cycles  out  32  saturating count of cycles with stall=1

Behaviour:
- Reset (rst=1 at posedge): all pending counters 0, sb_err 0, stall_cycles 0. Combinational outputs then evaluate from the inputs: iss_ready=1, stall=0, forwarding=00 per port when no hazards are present.
- Register index 0 is never tracked or forwarded. Issue/completion with waddr 0 is ignored. Source 0 always selects 00 and never stalls.
- Forwarding select, per port p with source s≠0, combinational, first match wins:
  - exe_mem_reg_wen && exe_mem_reg_waddr==s && !exe_mem_is_load → 01
  - mem_wb_reg_wen && mem_wb_reg_waddr==s → 10
  - cmpl_valid && cmpl_waddr==s && cnt[s]==1 → 11
  - otherwise → 00
- Stall (combinational). stall=1 iff id_exe_valid and some port p with s≠0 meets either condition:
  - load-use: exe_mem_reg_wen && exe_mem_is_load && exe_mem_reg_waddr==s.
  - scoreboard: cnt[s] − (cmpl_valid && cmpl_waddr==s) > 0.
- Scoreboard stall overrides any forwarding match; forwarding output is still driven, consumer ignores it while stall=1.
- iss_ready = (cnt[iss_waddr] < MAX_PENDING) || (cmpl_valid && cmpl_waddr==iss_waddr). Issue is accepted on iss_valid && iss_ready.
- Counter update at posedge, per register r:
  - +1 on accepted issue to r.
  - −1 on completion to r with cnt[r]>0.
  - Both in the same cycle → unchanged.
- Completion to r with cnt[r]==0 and no same-cycle issue to r: counter stays 0, sb_err←1 (sticky until rst).
- Issue with iss_valid && !iss_ready: dropped, no state change. Producer must hold iss_valid until ready.
- stall_cycles increments on every cycle with stall=1 and saturates at 0xFFFFFFFF.
- Latency: forwarding/stall/iss_ready 0 cycles (combinational). Scoreboard effects are visible the cycle after issue.
- rst asserted mid-operation clears all pending state. In-flight completions after reset raise sb_err; the pipeline must be flushed together with rst.

Test Plan:
- exe_mem wen, waddr=5, not load; port0 src=5; mem_wb also waddr=5 → forwarding[1:0]=01, stall=0.
- exe_mem load to x7, port1 src=7, id_exe_valid=1 → stall=1, stall_cycles +1. Same with id_exe_valid=0 → stall=0.
- Issue x9 at cycle 0. Port0 src=9 at cycle 1 → stall=1. cmpl x9 at cycle 4 → that cycle stall=0, forwarding[1:0]=11. Cycle 5 cnt[9]=0.
- Issue x3 three times (MAX_PENDING=3) → iss_ready=0 on the 4th. Drive issue and cmpl x3 in the same cycle → iss_ready=1, cnt stays 3.
- cmpl x4 with cnt[4]=0 → sb_err=1 and remains 1. rst → sb_err=0, all counters 0, stall_cycles=0.
- Any port src=0 with exe_mem wen waddr=0 load → forwarding=00, stall=0.
